// File: rtl/sine_freq_meter.sv
// sine_freq_meter
//   Recovers the phase increment of a sampled sine tone. Rising midpoint
//   crossings (with hysteresis) bound windows of NUM_PERIODS waveform cycles;
//   each window length is divided into 512*NUM_PERIODS by a 13-step restoring
//   divider to give p1_est.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   sample_in      10-bit offset-binary sample (midpoint 512), one per clock
//   p1_est         estimated phase increment, held until the next estimate
//   period_cycles  cycle count of the last completed window
//   est_valid      one-cycle pulse when p1_est / period_cycles update
//   locked         high after the first estimate; cleared by timeout/reset
//   timeout        one-cycle pulse when a window overruns the counter
module sine_freq_meter #(
  parameter int NUM_PERIODS = 8,
  parameter int HYST        = 16,
  parameter int CNT_W       = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       sample_in,
  output logic [12:0]      p1_est,
  output logic [CNT_W-1:0] period_cycles,
  output logic             est_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int LOGN  = $clog2(NUM_PERIODS);
  // Dividend 512*NUM_PERIODS split into the 13 bits the divider walks through
  // and the high part that pre-loads the remainder.
  localparam int DVD_W = 13 + LOGN;
  localparam logic [DVD_W-1:0] DIVIDEND = DVD_W'(512 * NUM_PERIODS);
  localparam logic [12:0]      DVD_LO   = DIVIDEND[12:0];
  localparam logic [LOGN-1:0]  DVD_HI   = DIVIDEND[DVD_W-1:13];

  localparam logic [9:0]       MID_LVL   = 10'd512;
  localparam logic [9:0]       ARM_LVL   = 10'(512 - HYST);
  // Timeout is decided in the cycle before cnt would reach 2^CNT_W-1, so the
  // pulse is visible in the cycle the count reaches it.
  localparam logic [CNT_W-1:0] CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [LOGN-1:0]  XCNT_LAST = LOGN'(NUM_PERIODS - 1);

  typedef enum logic {SEEK, MEASURE} state_e;

  state_e           state_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LOGN-1:0]  xcnt_q;

  logic             div_busy_q;
  logic [3:0]       div_idx_q;
  logic [CNT_W:0]   rem_q;
  logic [12:0]      quo_q;
  logic [CNT_W-1:0] divisor_q;
  logic             ovf_q;

  logic [12:0]      p1_est_q;
  logic [CNT_W-1:0] period_q;
  logic             est_valid_q;
  logic             locked_q;
  logic             timeout_q;

  logic             crossing;
  logic             timeout_hit;
  logic             window_end;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   rem_shift;
  logic             rem_ge;
  logic [CNT_W:0]   rem_d;
  logic [12:0]      quo_d;

  // NOTE: every signal here is assigned on every pass, so no latch can form.
  always_comb begin
    crossing    = armed_q && (sample_in >= MID_LVL);
    timeout_hit = (state_q == MEASURE) && (cnt_q == CNT_LAST);
    // Timeout outranks a window-ending crossing in the same cycle.
    window_end  = (state_q == MEASURE) && crossing && (xcnt_q == XCNT_LAST) && !timeout_hit;
    cnt_inc     = cnt_q + 1'b1;
    // Remainder stays below the divisor, so the shift never loses its MSB.
    rem_shift   = {rem_q[CNT_W-1:0], DVD_LO[div_idx_q]};
    rem_ge      = (rem_shift >= {1'b0, divisor_q});
    rem_d       = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    quo_d       = {quo_q[11:0], rem_ge};
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SEEK;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      xcnt_q      <= '0;
      div_busy_q  <= 1'b0;
      div_idx_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      ovf_q       <= 1'b0;
      p1_est_q    <= '0;
      period_q    <= '0;
      est_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      est_valid_q <= 1'b0;
      timeout_q   <= 1'b0;

      // A low sample arms; the first arming-followed sample at/above midpoint
      // is the crossing and disarms. The two conditions are mutually exclusive.
      if (sample_in < ARM_LVL) begin
        armed_q <= 1'b1;
      end else if (crossing) begin
        armed_q <= 1'b0;
      end

      unique case (state_q)
        SEEK: begin
          if (crossing) begin
            state_q <= MEASURE;
            cnt_q   <= '0;
            xcnt_q  <= '0;
          end
        end
        MEASURE: begin
          if (timeout_hit) begin
            state_q   <= SEEK;
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            cnt_q     <= '0;
            xcnt_q    <= '0;
          end else if (window_end) begin
            // The ending crossing opens the next window.
            cnt_q  <= '0;
            xcnt_q <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (crossing) begin
              xcnt_q <= xcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= SEEK;
      endcase

      // Divider: a new window restarts it (dropping any result in flight);
      // a timeout discards it.
      if (window_end) begin
        divisor_q  <= cnt_inc;
        rem_q      <= (CNT_W+1)'(DVD_HI);
        ovf_q      <= (CNT_W'(DVD_HI) >= cnt_inc);
        quo_q      <= '0;
        div_idx_q  <= 4'd12;
        div_busy_q <= 1'b1;
      end else if (timeout_hit) begin
        div_busy_q <= 1'b0;
      end else if (div_busy_q) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        div_idx_q <= div_idx_q - 1'b1;
        if (div_idx_q == 4'd0) begin
          div_busy_q  <= 1'b0;
          p1_est_q    <= ovf_q ? 13'h1FFF : quo_d;
          period_q    <= divisor_q;
          est_valid_q <= 1'b1;
          locked_q    <= 1'b1;
        end
      end
    end
  end

  assign p1_est        = p1_est_q;
  assign period_cycles = period_q;
  assign est_valid     = est_valid_q;
  assign locked        = locked_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Directed bench for sine_freq_meter: a default instance (CNT_W=20) and a
// short-counter instance (CNT_W=8) share clock, reset and sample stream.
// Inputs are driven at the falling edge; outputs read right after driving
// belong to the current cycle (index rel-1).
module tb_sine_freq_meter;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  sample_in;

  logic [12:0] p1_est;
  logic [19:0] period_cycles;
  logic        est_valid, locked, timeout;

  logic [12:0] p1_est_s;
  logic [7:0]  period_s;
  logic        est_valid_s, locked_s, timeout_s;

  sine_freq_meter #(.NUM_PERIODS(8), .HYST(16), .CNT_W(20)) u_dut (
    .clock         (clock),
    .reset         (reset),
    .sample_in     (sample_in),
    .p1_est        (p1_est),
    .period_cycles (period_cycles),
    .est_valid     (est_valid),
    .locked        (locked),
    .timeout       (timeout)
  );

  sine_freq_meter #(.NUM_PERIODS(8), .HYST(16), .CNT_W(8)) u_dut_small (
    .clock         (clock),
    .reset         (reset),
    .sample_in     (sample_in),
    .p1_est        (p1_est_s),
    .period_cycles (period_s),
    .est_valid     (est_valid_s),
    .locked        (locked_s),
    .timeout       (timeout_s)
  );

  always #5 clock = ~clock;

  typedef enum {M_SQ, M_SINE, M_HOLD} mode_e;

  mode_e mode;
  int sq_lo, sq_hi, sq_half, sq_ph;
  int acc, p1, hold_v;
  int rel;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] sine_val(input int a);
    real s;
    int  v;
    s = 511.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 512.0);
    v = 512 + ((s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5));
    return 10'(v);
  endfunction

  task automatic step();
    @(negedge clock);
    case (mode)
      M_SQ: begin
        sample_in = 10'((sq_ph < sq_half) ? sq_lo : sq_hi);
        sq_ph     = (sq_ph + 1) % (2 * sq_half);
      end
      M_SINE: begin
        sample_in = sine_val(acc);
        acc       = (acc + p1) % 512;
      end
      default: sample_in = 10'(hold_v);
    endcase
    rel++;
  endtask

  task automatic start_sq(input int lo, input int hi, input int half);
    mode = M_SQ; sq_lo = lo; sq_hi = hi; sq_half = half; sq_ph = 0; rel = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    sample_in = 10'd600;
    mode      = M_HOLD;
    hold_v    = 600;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // which: 0 = main est_valid, 1 = small est_valid, 2 = small timeout.
  task automatic wait_sig(input int which, input int limit, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      hit = (which == 0) ? est_valid : (which == 1) ? est_valid_s : timeout_s;
      if (hit === 1'b1) begin
        at = rel - 1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int n_est;

    reset = 1'b1; sample_in = 10'd0; mode = M_HOLD; hold_v = 0; rel = 0;
    sq_lo = 0; sq_hi = 0; sq_half = 1; sq_ph = 0; acc = 0; p1 = 0;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_p1_est", p1_est, 0);
    check("rst_period", period_cycles, 0);
    check("rst_est_valid", est_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);

    // Square 20 low / 20 high: crossing #9 at index 340, estimate at 354
    reset = 1'b0;
    start_sq(0, 1023, 20);
    step();
    check("sq_unlocked_at_start", locked, 0);
    wait_sig(0, 400, at);
    check("sq_est1_cycle", at, 354);
    check("sq_est1_p1", p1_est, 12);
    check("sq_est1_period", period_cycles, 320);
    check("sq_est1_locked", locked, 1);
    step();
    check("sq_est_pulse_width", est_valid, 0);
    wait_sig(0, 400, at);
    check("sq_est2_cycle", at, 674);
    check("sq_est2_p1", p1_est, 12);

    // Asynchronous reset while divider works on the window ending at 980
    while (rel < 986) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_p1_est", p1_est, 0);
    check("async_rst_period", period_cycles, 0);
    check("async_rst_est_valid", est_valid, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_timeout", timeout, 0);
    repeat (3) step();
    reset = 1'b0;
    start_sq(0, 1023, 20);
    wait_sig(0, 400, at);
    check("post_rst_est_cycle", at, 354);
    check("post_rst_p1", p1_est, 12);
    check("post_rst_locked", locked, 1);

    // Hysteresis: low level 500 never arms; 495 does
    do_reset();
    start_sq(500, 1023, 20);
    n_est = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (est_valid === 1'b1) n_est++;
    end
    check("hyst_500_no_est", n_est, 0);
    check("hyst_500_locked", locked, 0);
    sq_lo = 495;
    wait_sig(0, 900, at);
    check("hyst_495_est_cycle", at, 754);
    check("hyst_495_p1", p1_est, 12);
    check("hyst_495_locked", locked, 1);

    // Sine loopback p1=13: first crossing at index 40, windows of 315
    do_reset();
    mode = M_SINE; acc = 0; p1 = 13; rel = 0;
    wait_sig(0, 3000, at);
    check("sine13_est1_cycle", at, 369);
    check("sine13_est1_p1", p1_est, 13);
    check("sine13_est1_period", period_cycles, 315);
    wait_sig(0, 400, at);
    check("sine13_est2_cycle", at, 684);
    check("sine13_est2_p1", p1_est, 13);
    check("sine13_est2_period", period_cycles, 315);
    wait_sig(0, 400, at);
    check("sine13_est3_p1", p1_est, 13);

    // p1=47, then p1=88: second estimate after the change within +/-2
    p1 = 47;
    wait_sig(0, 400, at);
    wait_sig(0, 400, at);
    check("sine47_est_seen", (at >= 0), 1);
    check("sine47_est2_in_tol", (p1_est >= 13'd45 && p1_est <= 13'd49), 1);
    wait_sig(0, 400, at);
    check("sine47_est3_in_tol", (p1_est >= 13'd45 && p1_est <= 13'd49), 1);
    p1 = 88;
    wait_sig(0, 400, at);
    wait_sig(0, 400, at);
    check("sine88_est_seen", (at >= 0), 1);
    check("sine88_est2_in_tol", (p1_est >= 13'd86 && p1_est <= 13'd90), 1);
    wait_sig(0, 400, at);
    check("sine88_est3_in_tol", (p1_est >= 13'd86 && p1_est <= 13'd90), 1);

    // Timeout on the 8-bit counter instance: lock with 10/10 square
    // (window 160), then hold high after crossing #10 at index 190.
    // Last window restart is crossing #9 at 170, so timeout shows at 426.
    do_reset();
    start_sq(0, 1023, 10);
    wait_sig(1, 300, at);
    check("small_est_cycle", at, 184);
    check("small_est_p1", p1_est_s, 25);
    check("small_est_period", period_s, 160);
    while (rel < 191) step();
    check("small_locked_before_to", locked_s, 1);
    mode = M_HOLD; hold_v = 1023;
    wait_sig(2, 400, at);
    check("small_timeout_cycle", at, 426);
    check("small_timeout_unlocks", locked_s, 0);
    step();
    check("small_timeout_pulse_width", timeout_s, 0);
    start_sq(0, 1023, 10);
    wait_sig(1, 300, at);
    check("small_fresh_window_cycle", at, 184);
    check("small_fresh_p1", p1_est_s, 25);
    check("small_relocked", locked_s, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
